// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared definitions for the forwarding-source tracker: data/register widths,
// architectural register numbers, the "no register" marker and the hazard FSM
// state encoding. Imported by fwd_slot and fwd_source_tracker.
// -----------------------------------------------------------------------------
package fwd_pkg;

   localparam int REG_NUM_W = 4;
   localparam int DATA_W    = 16;

   localparam logic [REG_NUM_W-1:0] R0_NUM = 4'd0;
   localparam logic [REG_NUM_W-1:0] R1_NUM = 4'd1;
   localparam logic [REG_NUM_W-1:0] R2_NUM = 4'd2;
   localparam logic [REG_NUM_W-1:0] R3_NUM = 4'd3;
   localparam logic [REG_NUM_W-1:0] R4_NUM = 4'd4;
   localparam logic [REG_NUM_W-1:0] R5_NUM = 4'd5;
   localparam logic [REG_NUM_W-1:0] R6_NUM = 4'd6;
   localparam logic [REG_NUM_W-1:0] R7_NUM = 4'd7;
   localparam logic [REG_NUM_W-1:0] PC_NUM = 4'd8;
   localparam logic [REG_NUM_W-1:0] SP_NUM = 4'd9;

   // Published on a slot that carries no register write.
   localparam logic [REG_NUM_W-1:0] NO_REG = 4'hF;

   // Hazard FSM encoding, kept as plain constants for legacy tool flows.
   typedef logic [0:0] fsm_state_t;
   localparam fsm_state_t ST_IDLE  = 1'b0;
   localparam fsm_state_t ST_STALL = 1'b1;

   // Register numbers above SP do not exist; writes to them are dropped.
   function automatic logic is_legal_reg(input logic [REG_NUM_W-1:0] num);
      return num <= SP_NUM;
   endfunction

endpackage : fwd_pkg

// File: rtl/fwd_slot.sv
// -----------------------------------------------------------------------------
// fwd_slot
// One in-flight register-write slot. On an enabled edge it either captures the
// incoming write or, when d_wr is low, loads a bubble (num=NO_REG, value=0).
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   enable             capture strobe; state holds when low
//   d_num/d_value      incoming destination number and value
//   d_wr               incoming write flag (low => bubble)
//   d_is_load          incoming value is (or was) load data
//   num/value          held destination number and value
//   fwd_valid          slot holds a write whose value is final (not a load)
//   load_pend          slot holds a write that is a load
// -----------------------------------------------------------------------------
module fwd_slot
   import fwd_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [REG_NUM_W-1:0] d_num,
   input  logic [DATA_W-1:0]    d_value,
   input  logic                 d_wr,
   input  logic                 d_is_load,
   output logic [REG_NUM_W-1:0] num,
   output logic [DATA_W-1:0]    value,
   output logic                 fwd_valid,
   output logic                 load_pend
);

   logic wr_q;
   logic is_load_q;

   // NOTE: state registers use non-blocking assignments so every slot samples
   // the pre-edge value of its neighbour; blocking here would shift data through
   // both slots in one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num       <= NO_REG;
         value     <= '0;
         wr_q      <= 1'b0;
         is_load_q <= 1'b0;
      end else if (enable) begin
         if (d_wr) begin
            num       <= d_num;
            value     <= d_value;
            wr_q      <= 1'b1;
            is_load_q <= d_is_load;
         end else begin
            num       <= NO_REG;
            value     <= '0;
            wr_q      <= 1'b0;
            is_load_q <= 1'b0;
         end
      end
   end

   assign fwd_valid = wr_q & ~is_load_q;
   assign load_pend = wr_q &  is_load_q;

endmodule : fwd_slot

// File: rtl/fwd_source_tracker.sv
// -----------------------------------------------------------------------------
// fwd_source_tracker
// Producer side of the ALU-to-ALU forwarding path. Tracks the EX/MEM (slot 1)
// and MEM/WB (slot 2) register writes and publishes them to the forwarding
// unit, and raises stall for load-use hazards forwarding cannot cover.
// Optional feature macro: FWD_STALL_COUNT_EN adds a saturating stall_count.
// Parameters:
//   LOAD_STALL         bubble cycles per load-use hazard, legal 1..3
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   enable                             pipeline advance (0 = hold everything)
//   flush                              kill the instruction in EX
//   id_src1/2_num, id_src1/2_use       decode-stage sources and read flags
//   ex_dst_num, ex_wr_en, ex_is_load   EX destination, write flag, load flag
//   ex_result                          ALU result
//   mem_load_data                      load data for the load in slot 1
//   old_dst_1_num/_value, fwd_valid_1  slot 1 (Old_Dst_1, M2R1)
//   old_dst_2_num/_value, fwd_valid_2  slot 2 (Old_Dst_2, M2R2)
//   stall                              freeze IF/ID, bubble into EX
//   stall_count                        enabled stall cycles (macro only)
// -----------------------------------------------------------------------------
module fwd_source_tracker
   import fwd_pkg::*;
#(
   parameter int LOAD_STALL = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 flush,
   input  logic [REG_NUM_W-1:0] id_src1_num,
   input  logic [REG_NUM_W-1:0] id_src2_num,
   input  logic                 id_src1_use,
   input  logic                 id_src2_use,
   input  logic [REG_NUM_W-1:0] ex_dst_num,
   input  logic                 ex_wr_en,
   input  logic                 ex_is_load,
   input  logic [DATA_W-1:0]    ex_result,
   input  logic [DATA_W-1:0]    mem_load_data,
   output logic [REG_NUM_W-1:0] old_dst_1_num,
   output logic [DATA_W-1:0]    old_dst_1_value,
   output logic                 fwd_valid_1,
   output logic [REG_NUM_W-1:0] old_dst_2_num,
   output logic [DATA_W-1:0]    old_dst_2_value,
   output logic                 fwd_valid_2,
   output logic                 stall
`ifdef FWD_STALL_COUNT_EN
   ,
   output logic [15:0]          stall_count
`endif
);

   // The detection cycle is one stall cycle; STALL covers the remaining ones.
   localparam logic [1:0] CNT_INIT = (LOAD_STALL > 1) ? 2'(LOAD_STALL - 2) : 2'd0;

   // ---------------------------------------------------------------- slots
   logic ex_wr_flag;
   logic s1_load_pend;
   logic s2_fwd;
   logic s2_load_pend;
   logic [DATA_W-1:0] s2_value_in;

   assign ex_wr_flag = ex_wr_en && is_legal_reg(ex_dst_num) && !flush;

   fwd_slot u_slot1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .d_num     (ex_dst_num),
      .d_value   (ex_result),
      .d_wr      (ex_wr_flag),
      .d_is_load (ex_is_load),
      .num       (old_dst_1_num),
      .value     (old_dst_1_value),
      .fwd_valid (fwd_valid_1),
      .load_pend (s1_load_pend)
   );

   // A load leaving slot 1 picks up its memory data on the same edge.
   assign s2_value_in = s1_load_pend ? mem_load_data : old_dst_1_value;

   fwd_slot u_slot2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .d_num     (old_dst_1_num),
      .d_value   (s2_value_in),
      .d_wr      (fwd_valid_1 | s1_load_pend),
      .d_is_load (s1_load_pend),
      .num       (old_dst_2_num),
      .value     (old_dst_2_value),
      .fwd_valid (s2_fwd),
      .load_pend (s2_load_pend)
   );

   // Load data is resolved by slot 2, so any write held there is forwardable.
   assign fwd_valid_2 = s2_fwd | s2_load_pend;

   // ---------------------------------------------------------------- hazard FSM
   fsm_state_t state, state_nxt;
   logic [1:0] cnt, cnt_nxt;
   logic       src_hit;
   logic       hazard;

   assign src_hit = (id_src1_use && (id_src1_num == ex_dst_num)) ||
                    (id_src2_use && (id_src2_num == ex_dst_num));

   assign hazard = (state == ST_IDLE) && ex_is_load && ex_wr_en &&
                   is_legal_reg(ex_dst_num) && src_hit && !flush;

   // Mealy in the detection cycle, state-driven for the remaining cycles.
   assign stall = hazard || (state == ST_STALL);

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (flush) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = 2'd0;
      end else if (state == ST_STALL) begin
         if (cnt == 2'd0) state_nxt = ST_IDLE;
         else             cnt_nxt   = cnt - 2'd1;
      end else if (hazard && (LOAD_STALL > 1)) begin
         state_nxt = ST_STALL;
         cnt_nxt   = CNT_INIT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= 2'd0;
      end else if (enable) begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

`ifdef FWD_STALL_COUNT_EN
   // Saturating count of stall cycles on which the pipeline actually advanced.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= 16'h0000;
      end else if (enable && stall && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'h0001;
      end
   end
`endif

endmodule : fwd_source_tracker

// File: tb/tb_fwd_source_tracker.sv
// -----------------------------------------------------------------------------
// tb_fwd_source_tracker
// Self-checking bench for fwd_source_tracker. Two instances share stimulus:
// u_dut1 with LOAD_STALL=1 and u_dut3 with LOAD_STALL=3. Slot behaviour is
// driven from a vector table through an expectation queue; stall corner cases
// use short hand-written sequences. Honours FWD_STALL_COUNT_EN if defined.
// -----------------------------------------------------------------------------
module tb_fwd_source_tracker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b1;
   logic        flush = 1'b0;
   logic [3:0]  id_src1_num = 4'h0;
   logic [3:0]  id_src2_num = 4'h0;
   logic        id_src1_use = 1'b0;
   logic        id_src2_use = 1'b0;
   logic [3:0]  ex_dst_num = 4'h0;
   logic        ex_wr_en = 1'b0;
   logic        ex_is_load = 1'b0;
   logic [15:0] ex_result = 16'h0;
   logic [15:0] mem_load_data = 16'h0;

   logic [3:0]  d1_num1, d1_num2, d3_num1, d3_num2;
   logic [15:0] d1_val1, d1_val2, d3_val1, d3_val2;
   logic        d1_v1, d1_v2, d3_v1, d3_v2;
   logic        d1_stall, d3_stall;
`ifdef FWD_STALL_COUNT_EN
   logic [15:0] d1_cnt, d3_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fwd_source_tracker #(.LOAD_STALL(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
      .id_src1_num(id_src1_num), .id_src2_num(id_src2_num),
      .id_src1_use(id_src1_use), .id_src2_use(id_src2_use),
      .ex_dst_num(ex_dst_num), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
      .ex_result(ex_result), .mem_load_data(mem_load_data),
      .old_dst_1_num(d1_num1), .old_dst_1_value(d1_val1), .fwd_valid_1(d1_v1),
      .old_dst_2_num(d1_num2), .old_dst_2_value(d1_val2), .fwd_valid_2(d1_v2),
      .stall(d1_stall)
`ifdef FWD_STALL_COUNT_EN
      , .stall_count(d1_cnt)
`endif
   );

   fwd_source_tracker #(.LOAD_STALL(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
      .id_src1_num(id_src1_num), .id_src2_num(id_src2_num),
      .id_src1_use(id_src1_use), .id_src2_use(id_src2_use),
      .ex_dst_num(ex_dst_num), .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
      .ex_result(ex_result), .mem_load_data(mem_load_data),
      .old_dst_1_num(d3_num1), .old_dst_1_value(d3_val1), .fwd_valid_1(d3_v1),
      .old_dst_2_num(d3_num2), .old_dst_2_value(d3_val2), .fwd_valid_2(d3_v2),
      .stall(d3_stall)
`ifdef FWD_STALL_COUNT_EN
      , .stall_count(d3_cnt)
`endif
   );

   typedef struct packed {
      logic        en;
      logic [3:0]  dst;
      logic        wr;
      logic        ld;
      logic        fl;
      logic [15:0] res;
      logic [15:0] mem;
      logic        chk1;     // compare slot 1 num/value (skipped for loads)
      logic [3:0]  e1_num;
      logic [15:0] e1_val;
      logic        e1_v;
      logic [3:0]  e2_num;
      logic [15:0] e2_val;
      logic        e2_v;
   } vec_t;

   vec_t vecs [13];
   vec_t sb_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_ex(input logic [3:0] dst, input logic wr, input logic ld, input logic [15:0] res);
      ex_dst_num = dst;
      ex_wr_en   = wr;
      ex_is_load = ld;
      ex_result  = res;
   endtask

   // EX holds a load to R5 and the instruction in ID reads R5.
   task automatic drive_hazard();
      set_ex(4'd5, 1'b1, 1'b1, 16'h0050);
      id_src1_num = 4'd5;
      id_src1_use = 1'b1;
      id_src2_num = 4'd2;
      id_src2_use = 1'b1;
   endtask

   task automatic drive_bubble();
      set_ex(4'd0, 1'b0, 1'b0, 16'h0000);
      id_src1_use = 1'b0;
      id_src2_use = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      vec_t v;
      int   total1, total3, en3, k;
      bit   done;

      //            en   dst   wr   ld   fl   res       mem       chk1 e1_num e1_val    e1_v e2_num e2_val    e2_v
      vecs[0]  = '{1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 16'hABCD, 16'h0000, 1'b1, 4'h3, 16'hABCD, 1'b1, 4'hF, 16'h0000, 1'b0};
      vecs[1]  = '{1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 16'h2486, 16'h0000, 1'b1, 4'h9, 16'h2486, 1'b1, 4'h3, 16'hABCD, 1'b1};
      vecs[2]  = '{1'b1, 4'hC, 1'b1, 1'b0, 1'b0, 16'h5555, 16'h0000, 1'b1, 4'hF, 16'h0000, 1'b0, 4'h9, 16'h2486, 1'b1};
      vecs[3]  = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 4'h5, 16'h0040, 1'b0, 4'hF, 16'h0000, 1'b0};
      vecs[4]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h1234, 1'b1, 4'hF, 16'h0000, 1'b0, 4'h5, 16'h1234, 1'b1};
      vecs[5]  = '{1'b1, 4'h7, 1'b1, 1'b0, 1'b1, 16'h1111, 16'h0000, 1'b1, 4'hF, 16'h0000, 1'b0, 4'hF, 16'h0000, 1'b0};
      vecs[6]  = '{1'b1, 4'h8, 1'b1, 1'b0, 1'b0, 16'h0808, 16'h0000, 1'b1, 4'h8, 16'h0808, 1'b1, 4'hF, 16'h0000, 1'b0};
      vecs[7]  = '{1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h0000, 1'b1, 4'h3, 16'hBEEF, 1'b1, 4'h8, 16'h0808, 1'b1};
      vecs[8]  = '{1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 16'hCAFE, 16'h0000, 1'b1, 4'h3, 16'hCAFE, 1'b1, 4'h3, 16'hBEEF, 1'b1};
      vecs[9]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h9999, 1'b1, 4'h3, 16'hCAFE, 1'b1, 4'h3, 16'hBEEF, 1'b1};
      vecs[10] = '{1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 16'h0099, 16'h0000, 1'b0, 4'h1, 16'h0099, 1'b0, 4'h3, 16'hCAFE, 1'b1};
      vecs[11] = '{1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 16'h4444, 16'h5678, 1'b1, 4'h4, 16'h4444, 1'b1, 4'h1, 16'h5678, 1'b1};
      vecs[12] = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 4'hF, 16'h0000, 1'b0, 4'h4, 16'h4444, 1'b1};

      // ------------------------------------------------ reset state
      #12;
      check("rst num1", 32'(d1_num1), 32'hF);
      check("rst val1", 32'(d1_val1), 32'h0);
      check("rst v1",   32'(d1_v1),   32'h0);
      check("rst num2", 32'(d1_num2), 32'hF);
      check("rst val2", 32'(d1_val2), 32'h0);
      check("rst v2",   32'(d1_v2),   32'h0);
      check("rst stall3", 32'(d3_stall), 32'h0);
`ifdef FWD_STALL_COUNT_EN
      check("rst cnt3", 32'(d3_cnt), 32'h0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ------------------------------------------------ vector table
      for (int i = 0; i < 13; i++) begin
         enable        = vecs[i].en;
         flush         = vecs[i].fl;
         mem_load_data = vecs[i].mem;
         set_ex(vecs[i].dst, vecs[i].wr, vecs[i].ld, vecs[i].res);
         sb_q.push_back(vecs[i]);
         #1;
         check($sformatf("v%0d stall1", i), 32'(d1_stall), 32'h0);
         check($sformatf("v%0d stall3", i), 32'(d3_stall), 32'h0);
         tick();
         v = sb_q.pop_front();
         if (v.chk1) begin
            check($sformatf("v%0d num1", i), 32'(d1_num1), 32'(v.e1_num));
            check($sformatf("v%0d val1", i), 32'(d1_val1), 32'(v.e1_val));
         end
         check($sformatf("v%0d v1", i),   32'(d1_v1),   32'(v.e1_v));
         check($sformatf("v%0d num2", i), 32'(d1_num2), 32'(v.e2_num));
         check($sformatf("v%0d val2", i), 32'(d1_val2), 32'(v.e2_val));
         check($sformatf("v%0d v2", i),   32'(d1_v2),   32'(v.e2_v));
      end
      enable = 1'b1;
      flush  = 1'b0;
      mem_load_data = 16'h0000;

      // ------------------------------------------------ load-use, both depths
      drive_hazard();
      #1;
      check("lu stall1 detect", 32'(d1_stall), 32'h1);
      check("lu stall3 detect", 32'(d3_stall), 32'h1);
      tick();
      check("lu v1 after load", 32'(d1_v1), 32'h0);
      drive_bubble();
      mem_load_data = 16'h1234;
      #1;
      check("lu stall1 released", 32'(d1_stall), 32'h0);
      check("lu stall3 held", 32'(d3_stall), 32'h1);
      tick();
      mem_load_data = 16'h0000;
      check("lu num2", 32'(d1_num2), 32'h5);
      check("lu val2", 32'(d1_val2), 32'h1234);
      check("lu v2",   32'(d1_v2),   32'h1);
      check("lu stall3 last", 32'(d3_stall), 32'h1);
      tick();
      check("lu stall3 done", 32'(d3_stall), 32'h0);

      // ------------------------------------------------ enable gap mid-stall
      pulse_reset();
      total1 = 0;
      total3 = 0;
      en3    = 0;
      k      = 0;
      done   = 1'b0;
      while (!done && k < 20) begin
         if (k == 0) drive_hazard();
         else        drive_bubble();
         enable = !(k == 2 || k == 3);
         #1;
         if (d1_stall) total1++;
         if (d3_stall) begin
            total3++;
            if (enable) en3++;
         end
         if (k > 0 && !d3_stall) done = 1'b1;
         tick();
         k++;
      end
      enable = 1'b1;
      check("gap stall3 high cycles", 32'(total3), 32'd5);
      check("gap stall3 enabled cycles", 32'(en3), 32'd3);
      check("gap stall1 high cycles", 32'(total1), 32'd1);
`ifdef FWD_STALL_COUNT_EN
      check("gap cnt3", 32'(d3_cnt), 32'd3);
      check("gap cnt1", 32'(d1_cnt), 32'd1);
`endif

      // ------------------------------------------------ flush with hazard
      drive_hazard();
      flush = 1'b1;
      #1;
      check("flush stall1", 32'(d1_stall), 32'h0);
      check("flush stall3", 32'(d3_stall), 32'h0);
      tick();
      flush = 1'b0;
      check("flush num1", 32'(d1_num1), 32'hF);
      check("flush v1",   32'(d1_v1),   32'h0);
      drive_bubble();
      #1;
      check("flush no stall3 after", 32'(d3_stall), 32'h0);
      tick();

      // ------------------------------------------------ reset mid-stall
      set_ex(4'd6, 1'b1, 1'b0, 16'h6666);
      tick();
      drive_hazard();
      tick();
      drive_bubble();
      #1;
      check("rms stall3 before", 32'(d3_stall), 32'h1);
      check("rms num1 before", 32'(d3_num1), 32'h5);
      rst_n = 1'b0;
      #1;
      check("rms stall3 async", 32'(d3_stall), 32'h0);
      check("rms num1", 32'(d3_num1), 32'hF);
      check("rms num2", 32'(d3_num2), 32'hF);
`ifdef FWD_STALL_COUNT_EN
      check("rms cnt3", 32'(d3_cnt), 32'h0);
`endif
      #1;
      rst_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_fwd_source_tracker
